rggen_axi4lite_master: RTL and testbench

Single-outstanding AXI4-Lite initiator. Converts a simple valid/ready command port into AXI4-Lite read or write transactions on a rggen_axi4lite_if master modport, then returns the response on a valid/ready response port. Used by test/bring-up logic and bus bridges to drive rggen-generated register blocks, which are AXI4-Lite slaves.

---
 rtl/rggen_axi4lite_if.sv | 65 ++++++
 rtl/rggen_axi4lite_master.sv | 203 ++++++++++++++++++++
 tb/tb_rggen_axi4lite_master.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite bus bundle shared by rggen initiators and register-block slaves.
// The width-clip helper lives alongside it so both ends agree on the ID width.
package rggen_rtl_pkg;
    function automatic int rggen_clip_width(input int width);
        return (width > 0) ? width : 1;
    endfunction
endpackage

interface rggen_axi4lite_if #(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    localparam int ACTUAL_ID_WIDTH = rggen_rtl_pkg::rggen_clip_width(ID_WIDTH);

    logic                       awvalid;
    logic                       awready;
    logic [ACTUAL_ID_WIDTH-1:0] awid;
    logic [ADDRESS_WIDTH-1:0]   awaddr;
    logic [2:0]                 awprot;
    logic                       wvalid;
    logic                       wready;
    logic [BUS_WIDTH-1:0]       wdata;
    logic [BUS_WIDTH/8-1:0]     wstrb;
    logic                       bvalid;
    logic                       bready;
    logic [ACTUAL_ID_WIDTH-1:0] bid;
    logic [1:0]                 bresp;
    logic                       arvalid;
    logic                       arready;
    logic [ACTUAL_ID_WIDTH-1:0] arid;
    logic [ADDRESS_WIDTH-1:0]   araddr;
    logic [2:0]                 arprot;
    logic                       rvalid;
    logic                       rready;
    logic [ACTUAL_ID_WIDTH-1:0] rid;
    logic [1:0]                 rresp;
    logic [BUS_WIDTH-1:0]       rdata;

    modport master (
        output awvalid, awid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arprot,
        input  arready,
        input  rvalid, rid, rresp, rdata,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arprot,
        output arready,
        output rvalid, rid, rresp, rdata,
        input  rready
    );
endinterface

// File: rtl/rggen_axi4lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns a valid/ready command into one
// AXI4-Lite read or write and hands the response back on a valid/ready port.
module rggen_axi4lite_master #(
    parameter int  ID_WIDTH        = 0,
    parameter int  ADDRESS_WIDTH   = 16,
    parameter int  BUS_WIDTH       = 32,
    localparam int ACTUAL_ID_WIDTH = rggen_rtl_pkg::rggen_clip_width(ID_WIDTH)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_write,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_req_id,
    input  logic [ADDRESS_WIDTH-1:0]   i_req_address,
    input  logic [2:0]                 i_req_prot,
    input  logic [BUS_WIDTH-1:0]       i_req_write_data,
    input  logic [BUS_WIDTH/8-1:0]     i_req_strobe,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic                       o_rsp_write,
    output logic [ACTUAL_ID_WIDTH-1:0] o_rsp_id,
    output logic [1:0]                 o_rsp_status,
    output logic [BUS_WIDTH-1:0]       o_rsp_read_data,
    rggen_axi4lite_if.master           axi4lite_if
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WRITE_REQ = 3'd1;
    localparam logic [2:0] WRITE_RSP = 3'd2;
    localparam logic [2:0] READ_REQ  = 3'd3;
    localparam logic [2:0] READ_RSP  = 3'd4;
    localparam logic [2:0] RESPONSE  = 3'd5;

    logic [2:0]                 state_r;
    logic                       awvalid_r;
    logic                       wvalid_r;
    logic                       arvalid_r;
    logic                       bready_r;
    logic                       rready_r;
    logic                       rsp_valid_r;
    logic                       rsp_write_r;
    logic [ACTUAL_ID_WIDTH-1:0] id_r;
    logic [ADDRESS_WIDTH-1:0]   address_r;
    logic [2:0]                 prot_r;
    logic [BUS_WIDTH-1:0]       write_data_r;
    logic [BUS_WIDTH/8-1:0]     strobe_r;
    logic [1:0]                 rsp_status_r;
    logic [BUS_WIDTH-1:0]       rsp_read_data_r;
    logic                       req_ready_s;
    logic                       aw_done_s;
    logic                       w_done_s;
    logic                       unused_s;

    // Command acceptance and per-channel completion flags.
    always_comb begin
        req_ready_s = 1'b0;
        case (state_r)
            IDLE:    req_ready_s = 1'b1;
            default: req_ready_s = 1'b0;
        endcase
        if (awvalid_r) begin
            aw_done_s = axi4lite_if.awready;
        end else begin
            aw_done_s = 1'b1;
        end
        if (wvalid_r) begin
            w_done_s = axi4lite_if.wready;
        end else begin
            w_done_s = 1'b1;
        end
    end

    // Transaction FSM and AXI valid/ready handshake registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_req_valid && i_req_write) begin
                        state_r   <= WRITE_REQ;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                    end else if (i_req_valid) begin
                        state_r   <= READ_REQ;
                        arvalid_r <= 1'b1;
                    end
                end
                WRITE_REQ: begin
                    if (awvalid_r && axi4lite_if.awready) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && axi4lite_if.wready) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        state_r  <= WRITE_RSP;
                        bready_r <= 1'b1;
                    end
                end
                WRITE_RSP: begin
                    if (axi4lite_if.bvalid) begin
                        state_r     <= RESPONSE;
                        bready_r    <= 1'b0;
                        rsp_valid_r <= 1'b1;
                    end
                end
                READ_REQ: begin
                    if (axi4lite_if.arready) begin
                        state_r   <= READ_RSP;
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                    end
                end
                READ_RSP: begin
                    if (axi4lite_if.rvalid) begin
                        state_r     <= RESPONSE;
                        rready_r    <= 1'b0;
                        rsp_valid_r <= 1'b1;
                    end
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    bready_r    <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Command capture; an unused ID is forced to zero so awid/arid/o_rsp_id stay 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_write_r  <= 1'b0;
            id_r         <= {ACTUAL_ID_WIDTH{1'b0}};
            address_r    <= {ADDRESS_WIDTH{1'b0}};
            prot_r       <= 3'b000;
            write_data_r <= {BUS_WIDTH{1'b0}};
            strobe_r     <= {(BUS_WIDTH/8){1'b0}};
        end else if ((state_r == IDLE) && i_req_valid) begin
            rsp_write_r  <= i_req_write;
            id_r         <= (ID_WIDTH == 0) ? {ACTUAL_ID_WIDTH{1'b0}} : i_req_id;
            address_r    <= i_req_address;
            prot_r       <= i_req_prot;
            write_data_r <= i_req_write_data;
            strobe_r     <= i_req_strobe;
        end
    end

    // Response capture from B or R; read data is cleared on writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_status_r    <= 2'b00;
            rsp_read_data_r <= {BUS_WIDTH{1'b0}};
        end else if ((state_r == WRITE_RSP) && axi4lite_if.bvalid) begin
            rsp_status_r    <= axi4lite_if.bresp;
            rsp_read_data_r <= {BUS_WIDTH{1'b0}};
        end else if ((state_r == READ_RSP) && axi4lite_if.rvalid) begin
            rsp_status_r    <= axi4lite_if.rresp;
            rsp_read_data_r <= axi4lite_if.rdata;
        end
    end

    // Response IDs from the slave are deliberately ignored.
    assign unused_s = ^{axi4lite_if.bid, axi4lite_if.rid};

    assign o_req_ready         = req_ready_s;
    assign o_rsp_valid         = rsp_valid_r;
    assign o_rsp_write         = rsp_write_r;
    assign o_rsp_id            = id_r;
    assign o_rsp_status        = rsp_status_r;
    assign o_rsp_read_data     = rsp_read_data_r;

    assign axi4lite_if.awvalid = awvalid_r;
    assign axi4lite_if.awid    = id_r;
    assign axi4lite_if.awaddr  = address_r;
    assign axi4lite_if.awprot  = prot_r;
    assign axi4lite_if.wvalid  = wvalid_r;
    assign axi4lite_if.wdata   = write_data_r;
    assign axi4lite_if.wstrb   = strobe_r;
    assign axi4lite_if.bready  = bready_r;
    assign axi4lite_if.arvalid = arvalid_r;
    assign axi4lite_if.arid    = id_r;
    assign axi4lite_if.araddr  = address_r;
    assign axi4lite_if.arprot  = prot_r;
    assign axi4lite_if.rready  = rready_r;
endmodule

// File: tb/tb_rggen_axi4lite_master.sv
// Directed bench for rggen_axi4lite_master: an ID_WIDTH=2 instance for the main
// scenarios and an ID_WIDTH=0 instance for the unused-ID case.
module tb_rggen_axi4lite_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // ID_WIDTH=2 instance
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_write;
    logic [1:0]  req_id, rsp_id, rsp_status;
    logic [15:0] req_address;
    logic [2:0]  req_prot;
    logic [31:0] req_wdata, rsp_rdata;
    logic [3:0]  req_strobe;

    rggen_axi4lite_if #(.ID_WIDTH(2), .ADDRESS_WIDTH(16), .BUS_WIDTH(32)) ax ();

    rggen_axi4lite_master #(.ID_WIDTH(2), .ADDRESS_WIDTH(16), .BUS_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_id(req_id), .i_req_address(req_address), .i_req_prot(req_prot),
        .i_req_write_data(req_wdata), .i_req_strobe(req_strobe),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
        .o_rsp_id(rsp_id), .o_rsp_status(rsp_status), .o_rsp_read_data(rsp_rdata),
        .axi4lite_if(ax)
    );

    // ID_WIDTH=0 instance
    logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_ready0, rsp_write0;
    logic [0:0]  req_id0, rsp_id0;
    logic [1:0]  rsp_status0;
    logic [15:0] req_address0;
    logic [2:0]  req_prot0;
    logic [31:0] req_wdata0, rsp_rdata0;
    logic [3:0]  req_strobe0;

    rggen_axi4lite_if #(.ID_WIDTH(0), .ADDRESS_WIDTH(16), .BUS_WIDTH(32)) ax0 ();

    rggen_axi4lite_master #(.ID_WIDTH(0), .ADDRESS_WIDTH(16), .BUS_WIDTH(32)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid0), .o_req_ready(req_ready0), .i_req_write(req_write0),
        .i_req_id(req_id0), .i_req_address(req_address0), .i_req_prot(req_prot0),
        .i_req_write_data(req_wdata0), .i_req_strobe(req_strobe0),
        .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0), .o_rsp_write(rsp_write0),
        .o_rsp_id(rsp_id0), .o_rsp_status(rsp_status0), .o_rsp_read_data(rsp_rdata0),
        .axi4lite_if(ax0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_id = 2'd0; req_address = 16'h0000;
        req_prot = 3'b000; req_wdata = 32'h0; req_strobe = 4'h0; rsp_ready = 1'b0;
        ax.awready = 1'b0; ax.wready = 1'b0; ax.arready = 1'b0;
        ax.bvalid = 1'b0; ax.bid = 2'd0; ax.bresp = 2'b00;
        ax.rvalid = 1'b0; ax.rid = 2'd0; ax.rresp = 2'b00; ax.rdata = 32'h0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_id0 = 1'b0; req_address0 = 16'h0000;
        req_prot0 = 3'b000; req_wdata0 = 32'h0; req_strobe0 = 4'h0; rsp_ready0 = 1'b1;
        ax0.awready = 1'b1; ax0.wready = 1'b1; ax0.arready = 1'b1;
        ax0.bvalid = 1'b1; ax0.bid = 1'b1; ax0.bresp = 2'b00;
        ax0.rvalid = 1'b1; ax0.rid = 1'b1; ax0.rresp = 2'b01; ax0.rdata = 32'hCAFE_F00D;

        // reset state
        tick(); tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_awvalid", ax.awvalid, 0);
        check("rst_wvalid", ax.wvalid, 0);
        check("rst_arvalid", ax.arvalid, 0);
        check("rst_bready", ax.bready, 0);
        check("rst_rready", ax.rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_awaddr", ax.awaddr, 0);
        check("rst_wdata", ax.wdata, 0);
        rst = 1'b0;

        // write with immediate AW/W/B
        ax.awready = 1'b1; ax.wready = 1'b1; ax.bvalid = 1'b1; ax.bresp = 2'b00;
        req_valid = 1'b1; req_write = 1'b1; req_id = 2'd0; req_address = 16'h0010;
        req_wdata = 32'hDEAD_BEEF; req_strobe = 4'hF;
        tick();                       // cycle 1
        req_valid = 1'b0;
        check("w1_awvalid_c1", ax.awvalid, 1);
        check("w1_wvalid_c1", ax.wvalid, 1);
        check("w1_awaddr", ax.awaddr, 16'h0010);
        check("w1_wdata", ax.wdata, 32'hDEAD_BEEF);
        check("w1_wstrb", ax.wstrb, 4'hF);
        check("w1_req_ready_c1", req_ready, 0);
        tick();                       // cycle 2
        check("w1_awvalid_c2", ax.awvalid, 0);
        check("w1_wvalid_c2", ax.wvalid, 0);
        check("w1_bready_c2", ax.bready, 1);
        check("w1_rsp_valid_c2", rsp_valid, 0);
        tick();                       // cycle 3
        ax.bvalid = 1'b0;
        check("w1_rsp_valid_c3", rsp_valid, 1);
        check("w1_rsp_status", rsp_status, 0);
        check("w1_rsp_rdata", rsp_rdata, 0);
        check("w1_rsp_write", rsp_write, 1);
        check("w1_bready_c3", ax.bready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("w1_idle_req_ready", req_ready, 1);
        check("w1_idle_rsp_valid", rsp_valid, 0);

        // write: W immediate, AW delayed to cycle 4
        ax.awready = 1'b0; ax.wready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_id = 2'd2; req_address = 16'h0104;
        req_prot = 3'b010; req_wdata = 32'hA5A5_5A5A; req_strobe = 4'h3;
        tick();                       // cycle 1
        req_valid = 1'b0;
        check("w2_wvalid_c1", ax.wvalid, 1);
        tick();                       // cycle 2
        check("w2_wvalid_c2", ax.wvalid, 0);
        check("w2_awvalid_c2", ax.awvalid, 1);
        check("w2_awaddr_c2", ax.awaddr, 16'h0104);
        check("w2_bready_c2", ax.bready, 0);
        tick();                       // cycle 3
        check("w2_awvalid_c3", ax.awvalid, 1);
        check("w2_awprot_c3", ax.awprot, 3'b010);
        tick();                       // cycle 4
        check("w2_awvalid_c4", ax.awvalid, 1);
        check("w2_awaddr_c4", ax.awaddr, 16'h0104);
        check("w2_bready_c4", ax.bready, 0);
        ax.awready = 1'b1;
        tick();                       // cycle 5
        ax.awready = 1'b0;
        check("w2_awvalid_c5", ax.awvalid, 0);
        check("w2_bready_c5", ax.bready, 1);
        ax.bvalid = 1'b1; ax.bresp = 2'b11;
        tick();                       // cycle 6
        ax.bvalid = 1'b0;
        check("w2_rsp_valid", rsp_valid, 1);
        check("w2_rsp_status", rsp_status, 2'b11);
        check("w2_rsp_id", rsp_id, 2'd2);
        check("w2_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // read with two wait cycles, then a second command held off by rsp_ready
        ax.arready = 1'b1; ax.wready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_id = 2'd3; req_address = 16'h0024;
        req_prot = 3'b001;
        tick();                       // cycle 1
        req_valid = 1'b0;
        check("r_arvalid_c1", ax.arvalid, 1);
        check("r_araddr", ax.araddr, 16'h0024);
        check("r_arid", ax.arid, 2'd3);
        check("r_arprot", ax.arprot, 3'b001);
        tick();                       // cycle 2
        ax.arready = 1'b0;
        check("r_arvalid_c2", ax.arvalid, 0);
        check("r_rready_c2", ax.rready, 1);
        tick();                       // cycle 3
        check("r_rready_c3", ax.rready, 1);
        check("r_rsp_valid_c3", rsp_valid, 0);
        tick();                       // cycle 4
        ax.rvalid = 1'b1; ax.rresp = 2'b10; ax.rdata = 32'h1234_5678; ax.rid = 2'd1;
        tick();                       // cycle 5
        ax.rvalid = 1'b0;
        check("r_rsp_valid", rsp_valid, 1);
        check("r_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("r_rsp_status", rsp_status, 2'b10);
        check("r_rsp_id", rsp_id, 2'd3);
        check("r_rsp_write", rsp_write, 0);
        check("r_rready_after", ax.rready, 0);
        req_valid = 1'b1; req_write = 1'b1; req_id = 2'd1; req_address = 16'h0030;
        req_wdata = 32'h0000_0000; req_strobe = 4'h0;
        for (int i = 0; i < 5; i++) begin
            check("bp_req_ready", req_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
            check("bp_awvalid", ax.awvalid, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_idle_req_ready", req_ready, 1);
        check("bp_idle_rsp_valid", rsp_valid, 0);
        tick();
        req_valid = 1'b0;
        check("bp_second_awvalid", ax.awvalid, 1);
        check("bp_second_wstrb", ax.wstrb, 4'h0);
        check("bp_second_awaddr", ax.awaddr, 16'h0030);

        // reset with AW/W pending
        tick();
        check("pre_rst_awvalid", ax.awvalid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_awvalid", ax.awvalid, 0);
        check("mrst_wvalid", ax.wvalid, 0);
        check("mrst_req_ready", req_ready, 1);
        check("mrst_awaddr", ax.awaddr, 0);
        check("mrst_wdata", ax.wdata, 0);
        check("mrst_rsp_id", rsp_id, 0);
        check("mrst_rsp_valid", rsp_valid, 0);

        // ID_WIDTH=0: write then read with nonzero bid/rid from the slave
        req_valid0 = 1'b1; req_write0 = 1'b1; req_id0 = 1'b1; req_address0 = 16'h0040;
        req_wdata0 = 32'h0000_00FF; req_strobe0 = 4'h1;
        tick();
        req_valid0 = 1'b0;
        check("id0_awid", ax0.awid, 0);
        check("id0_w_awvalid", ax0.awvalid, 1);
        tick();
        tick();
        check("id0_w_rsp_valid", rsp_valid0, 1);
        check("id0_w_rsp_id", rsp_id0, 0);
        tick();
        req_valid0 = 1'b1; req_write0 = 1'b0; req_address0 = 16'h0044;
        tick();
        req_valid0 = 1'b0;
        check("id0_arid", ax0.arid, 0);
        check("id0_r_arvalid", ax0.arvalid, 1);
        tick();
        tick();
        check("id0_r_rsp_valid", rsp_valid0, 1);
        check("id0_r_rsp_id", rsp_id0, 0);
        check("id0_r_rsp_rdata", rsp_rdata0, 32'hCAFE_F00D);
        check("id0_r_rsp_status", rsp_status0, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
